gcd_requester: RTL and testbench

//  Initiator side of the gcd go/done protocol. Buffers operand pairs from an upstream

---
 rtl/gcd_pkg.sv | 14 +
 rtl/gcd_requester_if.sv | 41 ++++
 rtl/gcd_req_fifo.sv | 51 +++++
 rtl/gcd_requester.sv | 144 ++++++++++++++
 tb/tb_gcd_requester.sv | 348 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gcd_pkg.sv
// Shared definitions for the gcd requester and the gcd core environment:
// FSM state encoding and the default operand width.
package gcd_pkg;

    localparam int GCD_WIDTH = 16;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_GO   = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } gcd_state_e;

endpackage

// File: rtl/gcd_requester_if.sv
// Bundle of the requester's three handshakes: upstream request stream,
// go/done link to the gcd core, and downstream result stream.
interface gcd_requester_if import gcd_pkg::*; #(
    parameter int WIDTH = GCD_WIDTH
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;

    logic             core_go;
    logic [WIDTH-1:0] core_a;
    logic [WIDTH-1:0] core_b;
    logic             core_done;
    logic [WIDTH-1:0] core_ans;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_a;
    logic [WIDTH-1:0] out_b;
    logic [WIDTH-1:0] out_gcd;
    logic             out_err;

    logic             busy;

    // Requester side
    modport master (
        input  in_valid, in_a, in_b, core_done, core_ans, out_ready,
        output in_ready, core_go, core_a, core_b,
        output out_valid, out_a, out_b, out_gcd, out_err, busy
    );

    // Environment side: upstream source, gcd core and downstream sink
    modport slave (
        output in_valid, in_a, in_b, core_done, core_ans, out_ready,
        input  in_ready, core_go, core_a, core_b,
        input  out_valid, out_a, out_b, out_gcd, out_err, busy
    );

endinterface

// File: rtl/gcd_req_fifo.sv
// Synchronous request FIFO. Pointers wrap naturally (DEPTH is a power of 2);
// a registered occupancy count drives full/empty.
module gcd_req_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

    // Entry storage; contents are meaningless while empty, so no reset
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/gcd_requester.sv
// Initiator side of the gcd go/done protocol. Queues operand pairs, resolves
// zero operands locally (the core never terminates on them), runs one core
// job at a time under a timeout, and returns results in request order.
module gcd_requester import gcd_pkg::*; #(
    parameter int WIDTH   = GCD_WIDTH,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 65535
) (
    input logic             clk,
    input logic             rst,
    gcd_requester_if.master bus
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int CW = $clog2(DEPTH) + 1;

    gcd_state_e         state;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic [TW-1:0]      timer;
    logic               go_q;
    logic               out_valid_q;
    logic               out_err_q;
    logic [WIDTH-1:0]   out_a_q;
    logic [WIDTH-1:0]   out_b_q;
    logic [WIDTH-1:0]   out_gcd_q;

    logic [2*WIDTH-1:0] head;
    logic [WIDTH-1:0]   head_a;
    logic [WIDTH-1:0]   head_b;
    logic               push;
    logic               pop;
    logic               full;
    logic               empty;
    logic [CW-1:0]      fifo_count;
    logic               head_zero;
    logic               timer_last;
    logic               first_wait;

    assign push       = bus.in_valid && !full;
    assign pop        = (state == S_IDLE) && !empty;
    assign head_a     = head[2*WIDTH-1:WIDTH];
    assign head_b     = head[WIDTH-1:0];
    assign head_zero  = (head_a == '0) || (head_b == '0);
    assign timer_last = (timer == TW'(TIMEOUT - 1));
    // The timer is cleared on entry to S_WAIT and never wraps back to zero,
    // so zero marks the first wait cycle, in which a stale done is ignored.
    assign first_wait = (timer == '0);

    gcd_req_fifo #(
        .WIDTH (2 * WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({bus.in_a, bus.in_b}),
        .pop       (pop),
        .pop_data  (head),
        .full      (full),
        .empty     (empty),
        .count     (fifo_count)
    );

    assign bus.in_ready  = !full;
    assign bus.core_go   = go_q;
    assign bus.core_a    = op_a;
    assign bus.core_b    = op_b;
    assign bus.out_valid = out_valid_q;
    assign bus.out_a     = out_a_q;
    assign bus.out_b     = out_b_q;
    assign bus.out_gcd   = out_gcd_q;
    assign bus.out_err   = out_err_q;
    assign bus.busy      = (state != S_IDLE) || (fifo_count != '0);

    // Job sequencer: pop, dispatch or resolve locally, supervise, respond
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            op_a        <= '0;
            op_b        <= '0;
            timer       <= '0;
            go_q        <= 1'b0;
            out_valid_q <= 1'b0;
            out_err_q   <= 1'b0;
            out_a_q     <= '0;
            out_b_q     <= '0;
            out_gcd_q   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!empty) begin
                        op_a <= head_a;
                        op_b <= head_b;
                        if (head_zero) begin
                            out_a_q     <= head_a;
                            out_b_q     <= head_b;
                            out_gcd_q   <= head_a | head_b;
                            out_err_q   <= 1'b0;
                            out_valid_q <= 1'b1;
                            state       <= S_RESP;
                        end else begin
                            go_q  <= 1'b1;
                            timer <= '0;
                            state <= S_GO;
                        end
                    end
                end
                S_GO: begin
                    go_q  <= 1'b0;
                    timer <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.core_done && !first_wait) begin
                        out_a_q     <= op_a;
                        out_b_q     <= op_b;
                        out_gcd_q   <= bus.core_ans;
                        out_err_q   <= 1'b0;
                        out_valid_q <= 1'b1;
                        state       <= S_RESP;
                    end else if (timer_last) begin
                        out_a_q     <= op_a;
                        out_b_q     <= op_b;
                        out_gcd_q   <= '0;
                        out_err_q   <= 1'b1;
                        out_valid_q <= 1'b1;
                        state       <= S_RESP;
                    end else if (timer != '1) begin
                        timer <= timer + 1'b1;
                    end
                end
                S_RESP: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_requester.sv
// Bench for gcd_requester: randomized and directed requests, a behavioural
// gcd core with configurable latency / hang, and a scoreboard-driven monitor.
module tb_gcd_requester;
    import gcd_pkg::*;

    localparam int W     = 16;
    localparam int DEPTH = 4;
    localparam int TO    = 20;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] g;
        logic         e;
        bit           core;
        int           exp_cyc;
    } resp_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           lat;
        bit           hang;
    } job_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    gcd_requester_if #(.WIDTH(W)) bus ();

    gcd_requester #(
        .WIDTH   (W),
        .DEPTH   (DEPTH),
        .TIMEOUT (TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    resp_t sb_q[$];
    job_t  job_q[$];
    int    tq[$];
    int    checks   = 0;
    int    errors   = 0;
    int    cyc      = 0;
    int    go_cnt   = 0;
    int    exp_go   = 0;
    int    rdy_mode = 1;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] a, input logic [W-1:0] b);
        int unsigned x, y, t;
        x = a;
        y = b;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return W'(x);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural gcd core: done is a level that stays up after completion
    // and drops one cycle after go, so the first wait cycle sees stale done.
    initial begin
        job_t         cur;
        bit           active, stale, go_prev;
        int           cnt;
        logic [W-1:0] res;
        active  = 0;
        stale   = 0;
        go_prev = 0;
        cnt     = 0;
        res     = '0;
        cur     = '{a: '0, b: '0, lat: 1, hang: 1'b0};
        bus.core_done = 1'b1;
        bus.core_ans  = 16'hdead;
        forever begin
            @(posedge clk);
            if (rst) begin
                bus.core_done <= 1'b0;
                active  = 0;
                stale   = 0;
                go_prev = 0;
            end else if (bus.core_go) begin
                go_cnt++;
                check("core_go_single_pulse", go_prev, 0);
                if (job_q.size() == 0) begin
                    check("core_go_expected", 0, 1);
                end else begin
                    cur = job_q.pop_front();
                    check("core_a", bus.core_a, cur.a);
                    check("core_b", bus.core_b, cur.b);
                    res    = ref_gcd(cur.a, cur.b);
                    active = 1;
                    stale  = 1;
                    if (cur.hang || cur.lat > TO - 2) tq.push_back(cyc + 1 + TO);
                    else                              tq.push_back(cyc + 3 + cur.lat);
                end
            end else if (stale) begin
                bus.core_done <= 1'b0;
                bus.core_ans  <= W'($urandom);
                stale = 0;
                cnt   = cur.lat;
            end else if (active && !cur.hang) begin
                if (cnt <= 1) begin
                    bus.core_done <= 1'b1;
                    bus.core_ans  <= res;
                    active = 0;
                end else begin
                    cnt--;
                end
            end
            go_prev = bus.core_go;
        end
    end

    // Downstream sink: out_ready pattern chosen by rdy_mode
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       bus.out_ready = 1'b0;
                1:       bus.out_ready = 1'b1;
                default: bus.out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: pop the scoreboard on each new response, check hold while stalled
    initial begin
        resp_t mon_r;
        bit    prev_v;
        prev_v = 0;
        mon_r  = '{a: '0, b: '0, g: '0, e: 1'b0, core: 1'b0, exp_cyc: -1};
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_v = 0;
            end else begin
                if (bus.out_valid && !prev_v) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected_out_valid", 1, 0);
                    end else begin
                        mon_r = sb_q.pop_front();
                        check("out_a", bus.out_a, mon_r.a);
                        check("out_b", bus.out_b, mon_r.b);
                        check("out_gcd", bus.out_gcd, mon_r.g);
                        check("out_err", bus.out_err, mon_r.e);
                        if (mon_r.core) begin
                            if (tq.size() == 0) check("core_job_dispatched", 0, 1);
                            else                check("core_resp_cycle", cyc, tq.pop_front());
                        end else if (mon_r.exp_cyc >= 0) begin
                            check("zero_op_latency", cyc, mon_r.exp_cyc);
                        end
                    end
                end else if (bus.out_valid) begin
                    check("out_hold", {bus.out_a, bus.out_b, bus.out_gcd, bus.out_err},
                          {mon_r.a, mon_r.b, mon_r.g, mon_r.e});
                end
                prev_v = bus.out_valid;
            end
        end
    end

    bit saw_stall;

    task automatic push(input logic [W-1:0] a, input logic [W-1:0] b,
                        input int lat, input bit hang, input bit lat_chk);
        resp_t r;
        job_t  j;
        bit    acc, zero, late;
        int    budget;
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        acc    = 0;
        budget = 0;
        while (!acc && budget < 500) begin
            acc = bus.in_ready;
            if (!acc) saw_stall = 1;
            @(posedge clk);
            #1;
            budget++;
        end
        bus.in_valid = 1'b0;
        if (!acc) begin
            check("push_accepted", 0, 1);
        end else begin
            zero      = (a == '0) || (b == '0);
            late      = hang || (lat > TO - 2);
            r.a       = a;
            r.b       = b;
            r.core    = !zero;
            r.e       = !zero && late;
            r.g       = r.e ? '0 : ref_gcd(a, b);
            r.exp_cyc = (zero && lat_chk) ? cyc + 1 : -1;
            sb_q.push_back(r);
            if (!zero) begin
                j.a    = a;
                j.b    = b;
                j.lat  = lat;
                j.hang = hang;
                job_q.push_back(j);
                exp_go++;
            end
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((bus.busy || sb_q.size() != 0) && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_to_idle", bus.busy || sb_q.size() != 0, 0);
    endtask

    initial begin
        int unsigned k, x, y;
        int          n;
        bit          stale_seen;
        bus.in_valid = 1'b0;
        bus.in_a     = '0;
        bus.in_b     = '0;
        saw_stall    = 0;

        // Reset state
        rst = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_core_go", bus.core_go, 0);
        check("rst_core_ab", {bus.core_a, bus.core_b}, 0);
        check("rst_out_data", {bus.out_a, bus.out_b, bus.out_gcd, bus.out_err}, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Single core job
        push(16'd48, 16'd18, 10, 0, 0);
        wait_idle();

        // Zero operands resolved locally, with latency checked from an empty FIFO
        push(16'd0, 16'd35, 1, 0, 1);
        wait_idle();
        push(16'd0, 16'd0, 1, 0, 1);
        wait_idle();
        push(16'd27, 16'd0, 1, 0, 1);
        wait_idle();

        // Back-to-back with a stalled sink: FIFO fills while job 1 is at the core
        rdy_mode = 0;
        push(16'd100, 16'd75, 3, 0, 0);
        push(16'd81,  16'd54, 2, 0, 0);
        push(16'd0,   16'd9,  1, 0, 0);
        push(16'd121, 16'd11, 5, 0, 0);
        push(16'd64,  16'd40, 1, 0, 0);
        check("in_ready_full", bus.in_ready, 0);
        repeat (20) begin @(posedge clk); #1; end
        check("in_ready_still_full", bus.in_ready, 0);
        rdy_mode = 1;
        wait_idle();

        // Timeout on a hung core, then a normal job
        push(16'd200, 16'd150, 1, 1, 0);
        push(16'd84,  16'd36,  5, 0, 0);
        wait_idle();

        // Done in the timer's last cycle wins; one cycle later is a timeout
        push(16'd91, 16'd35, 18, 0, 0);
        push(16'd91, 16'd35, 19, 0, 0);
        push(16'd91, 16'd35, 17, 0, 0);
        wait_idle();

        // Randomized traffic with a random sink
        rdy_mode = 2;
        for (int i = 0; i < 40; i++) begin
            k = $urandom_range(1, 255);
            x = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 255);
            y = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 255);
            push(W'(k * x), W'(k * y), $urandom_range(1, 12), $urandom_range(0, 9) == 0, 0);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 4)) begin @(posedge clk); #1; end
            end
        end
        rdy_mode = 1;
        wait_idle();

        // Reset while a job waits at the core and two requests are queued
        push(16'd60, 16'd45, 15, 0, 0);
        push(16'd70, 16'd21, 3, 0, 0);
        push(16'd99, 16'd33, 3, 0, 0);
        n = 0;
        while (!bus.core_go && n < 200) begin @(posedge clk); #1; n++; end
        check("go_before_reset", bus.core_go, 1);
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        sb_q.delete();
        job_q.delete();
        tq.delete();
        exp_go = go_cnt;
        check("mid_rst_core_go", bus.core_go, 0);
        check("mid_rst_out_valid", bus.out_valid, 0);
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_in_ready", bus.in_ready, 1);
        rst = 1'b0;
        stale_seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.out_valid || bus.core_go || bus.busy) stale_seen = 1;
        end
        check("no_stale_after_reset", stale_seen, 0);
        push(16'd120, 16'd84, 4, 0, 0);
        wait_idle();

        check("core_go_count", go_cnt, exp_go);
        check("scoreboard_empty", sb_q.size(), 0);
        check("timing_queue_empty", tq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global bound on simulation length
    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule
